gate_sequencer: RTL and testbench
=================================

// Module: gate_sequencer
// PURPOSE
//  Drives the enables of the NAND clock-gate cells. One enable per machine phase.
//  A one-hot phase ring spans one instruction cycle of PHASES clocks.
//  It provides run, halt, single-step and counted-burst control for the core.
//  It is the producer side of the gate protocol: each gate cell samples en on the rising clk edge.
//  A sampled-high en passes exactly one clock pulse for that phase.
// PARAMETERS
//  PHASES  4  number of phase enables; one instruction cycle = PHASES clocks (>=2)
//  CNT_W   8  width of the burst instruction counter
// PORTS
//  clk        in   1       system clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  run        in   1       level: free-run instructions while high
//  step       in   1       pulse: execute exactly one instruction (from IDLE only)
//  burst_go   in   1       pulse: execute burst_len instructions (from IDLE only)
//  burst_len  in   CNT_W   burst length, sampled on burst_go; 0 = no-op
//  halt       in   1       pulse/level: stop at next instruction boundary
//  en         out  PHASES  one-hot (or zero) registered gate enables
//  phase      out  $clog2(PHASES)  index of the currently enabled phase
//  busy       out  1       high whenever not IDLE
//  done       out  1       1-clk pulse when a step or burst completes, or on a halt stop
// BEHAVIOUR
//  - Reset: state=IDLE, en=0, phase=0, busy=0, done=0, counter=0. Takes priority over all inputs.
//  - en is a flop output only. It never has combinational input paths; it changes only just after the rising clk edge.
//  - States: IDLE, RUN, STEP, BURST, STOP.
//  - IDLE: en=0.
//    - Entry priority (same cycle): run > step > burst_go.
//    - burst_go with burst_len=0 stays in IDLE and pulses done next clk.
//    - Otherwise the next clk enters the chosen state with en=1<<0, phase=0.
//  - Active states: en rotates left one bit per clk (phase 0..PHASES-1).
//    - Wrap from PHASES-1 to 0 is the instruction boundary.
//  - Instruction boundary = cycle where phase==PHASES-1.
//    - STEP: go to IDLE, en=0, done=1 for 1 clk.
//    - BURST: decrement counter; if counter was 1, go to IDLE with done=1, else continue at phase 0.
//    - RUN: if run low or halt seen, go to IDLE with done=1; else continue.
//  - halt is captured into a sticky flag in any active state and cleared on return to IDLE.
//    - Never truncates an instruction: all PHASES enables of the current instruction are issued.
//  - halt in IDLE is ignored (no done).
//  - run dropping mid-instruction: finish the instruction, then IDLE (same as halt).
//  - step/burst_go while busy: ignored, no queuing. run rising during STEP/BURST: ignored.
//  - STOP: reserved single-cycle state after boundary when done is pulsed; en=0; returns to IDLE.
//    - Back-to-back restart is therefore allowed on the clk after done.
//  - Counter: CNT_W bits, loaded with burst_len on entry, never wraps (no decrement below 1).
//  - Invariant: popcount(en) <= 1 in every cycle; en!=0 iff state in {RUN,STEP,BURST}.
//  - Mid-operation rst: en=0 on the next edge; the partial instruction is abandoned.
// STRUCTURE
//  - Shared package gate_pkg: state enum (IDLE,RUN,STEP,BURST,STOP), PHASES default, phase-index width function.
//  - One sub-module, phase_ring: one-hot rotating register with load/clear/advance, outputs en and phase.
//  - The FSM, counter and halt flag live in gate_sequencer.
// TESTING
//  - Reset: hold rst 3 clks with run=1 -> en=0, busy=0, done=0 throughout; release -> RUN starts next clk with en=4'b0001.
//  - Step: step pulse in IDLE -> en 0001,0010,0100,1000, then 0000; done high exactly 1 clk; busy high 5 clks.
//  - Burst: burst_len=3, burst_go -> 12 consecutive one-hot enables, then one done. burst_len=0 -> done only, en never nonzero.
//  - Halt mid-instruction: run=1, halt pulse at phase 1 of instr 2 -> phases 2,3 still issued, then IDLE and done.
//  - Ignored requests: step/burst_go during a burst and halt in IDLE -> no change in enable count, no extra done.
//  - Reset mid-burst: rst at phase 2 -> en=0 next clk, counter=0. A following step yields exactly PHASES enables.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the clock-gate enable sequencer.
package gate_pkg;

  localparam int PHASES_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    BURST = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Width of a phase index; never less than one bit.
  function automatic int phase_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/phase_ring.sv
// One-hot rotating phase register: load starts at phase 0, advance rotates
// left with wrap, clear (or rst) drops every enable.
module phase_ring
  import gate_pkg::*;
#(
  parameter int PHASES = PHASES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         clear,
  input  logic                         advance,
  output logic [PHASES-1:0]            en,
  output logic [phase_w(PHASES)-1:0]   phase
);

  localparam int PW = phase_w(PHASES);

  // Registered enables and phase index; clear wins over load, load over advance.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      en    <= '0;
      phase <= '0;
    end else if (load) begin
      en    <= PHASES'(1);
      phase <= '0;
    end else if (advance) begin
      en    <= {en[PHASES-2:0], en[PHASES-1]};
      phase <= (phase == PW'(PHASES-1)) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// Gate-enable sequencer: run / single-step / counted-burst control of a
// one-hot phase ring, stopping only on instruction boundaries.
module gate_sequencer
  import gate_pkg::*;
#(
  parameter int PHASES = PHASES_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         step,
  input  logic                         burst_go,
  input  logic [CNT_W-1:0]             burst_len,
  input  logic                         halt,
  output logic [PHASES-1:0]            en,
  output logic [phase_w(PHASES)-1:0]   phase,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = phase_w(PHASES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             halt_flag;
  logic             active;
  logic             boundary;
  logic             ring_load, ring_clear, ring_adv;
  logic             done_n;

  assign active   = (state == RUN) || (state == STEP) || (state == BURST);
  assign boundary = active && (phase == PW'(PHASES-1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: entry priority run > step > burst_go; exits only at a boundary.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (run)                                state_n = RUN;
        else if (step)                          state_n = STEP;
        else if (burst_go && burst_len != '0)   state_n = BURST;
      end
      RUN:   if (boundary && (!run || halt || halt_flag)) state_n = STOP;
      STEP:  if (boundary) state_n = STOP;
      BURST: if (boundary && (cnt == CNT_W'(1) || halt || halt_flag)) state_n = STOP;
      STOP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs and ring controls derived from the current/next state.
  always_comb begin
    busy       = (state != IDLE);
    ring_load  = (state == IDLE) && (state_n != IDLE);
    ring_adv   = active && (state_n == state);
    ring_clear = active && (state_n == STOP);
    done_n     = ring_clear ||
                 ((state == IDLE) && !run && !step && burst_go && (burst_len == '0));
  end

  // done is registered so it lines up with STOP (or the cycle after a zero burst).
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= done_n;
  end

  // Burst counter: loaded on entry, decremented per boundary, never below 1.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((state == IDLE) && (state_n == BURST))
      cnt <= burst_len;
    else if ((state == BURST) && boundary && (cnt > CNT_W'(1)))
      cnt <= cnt - CNT_W'(1);
  end

  // Sticky halt request, held while active and dropped once back out.
  always_ff @(posedge clk) begin
    if (rst || !active) halt_flag <= 1'b0;
    else if (halt)      halt_flag <= 1'b1;
  end

  phase_ring #(.PHASES(PHASES)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .load    (ring_load),
    .clear   (ring_clear),
    .advance (ring_adv),
    .en      (en),
    .phase   (phase)
  );

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer with an instruction-level reference model.
module tb_gate_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0, step = 1'b0, burst_go = 1'b0, halt = 1'b0;
  logic [7:0] burst_len = '0;
  logic [3:0] en;
  logic [1:0] phase;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: what kind of work is in progress, which phase of the
  // current instruction, how many burst instructions remain.
  int m_kind = 0;   // 0 none, 1 run, 2 step, 3 burst
  int m_phase = 0;
  int m_left = 0;
  bit m_halt = 0;
  bit m_stop = 0;
  bit m_done = 0;

  gate_sequencer #(.PHASES(P), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .burst_go(burst_go),
    .burst_len(burst_len), .halt(halt), .en(en), .phase(phase),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_vec();
    logic [3:0] e;
    logic [1:0] ph;
    e  = (m_kind != 0) ? (4'b0001 << m_phase) : 4'b0000;
    ph = (m_kind != 0) ? 2'(m_phase) : 2'd0;
    return {e, ph, (m_kind != 0) || m_stop, m_done};
  endfunction

  task automatic model_step();
    bit nd, hs, fin;
    if (rst) begin
      m_kind = 0; m_phase = 0; m_left = 0; m_halt = 0; m_stop = 0; m_done = 0;
    end else begin
      nd = 0;
      if (m_stop) begin
        m_stop = 0;
      end else if (m_kind == 0) begin
        if (run)           begin m_kind = 1; m_phase = 0; end
        else if (step)     begin m_kind = 2; m_phase = 0; end
        else if (burst_go) begin
          if (burst_len == 0) nd = 1;
          else begin m_kind = 3; m_phase = 0; m_left = burst_len; end
        end
      end else begin
        hs = m_halt || halt;
        if (m_phase == P - 1) begin
          fin = (m_kind == 2) || (m_kind == 1 && (!run || hs)) ||
                (m_kind == 3 && (m_left == 1 || hs));
          if (m_kind == 3 && m_left > 1) m_left--;
          if (fin) begin m_kind = 0; m_stop = 1; nd = 1; m_halt = 0; end
          else begin m_phase = 0; m_halt = hs; end
        end else begin
          m_phase++;
          m_halt = hs;
        end
      end
      m_done = nd;
    end
  endtask

  // One clock: model follows the inputs sampled at the edge; sampling at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({en, busy, done} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got en=%b busy=%b done=%b want 0/0/0", i, en, busy, done);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (en !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got en=%b busy=%b want 0001/1", en, busy);
    end
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({en, phase, busy, done} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_drain[%0d]: got %b want %b", i, {en, phase, busy, done}, exp_vec());
      end
    end
  endtask

  task automatic test_step();
    int n_en = 0, n_done = 0, n_busy = 0;
    for (int i = 0; i < 8; i++) begin
      step = (i == 0);
      tick();
      step = 1'b0;
      n_en += (en != 0); n_done += done; n_busy += busy;
      checks++;
      if ({en, phase, busy, done} !== exp_vec()) begin
        errors++;
        $display("FAIL step[%0d]: got %b want %b", i, {en, phase, busy, done}, exp_vec());
      end
    end
    checks++;
    if (n_en != P || n_done != 1 || n_busy != P + 1) begin
      errors++;
      $display("FAIL step_counts: got en=%0d done=%0d busy=%0d want %0d/1/%0d", n_en, n_done, n_busy, P, P + 1);
    end
  endtask

  task automatic test_burst();
    int n_en = 0, n_done = 0, n_busy = 0;
    burst_len = 8'd3;
    for (int i = 0; i < 16; i++) begin
      burst_go = (i == 0);
      tick();
      burst_go = 1'b0;
      n_en += (en != 0); n_done += done;
      checks++;
      if ({en, phase, busy, done} !== exp_vec()) begin
        errors++;
        $display("FAIL burst3[%0d]: got %b want %b", i, {en, phase, busy, done}, exp_vec());
      end
    end
    checks++;
    if (n_en != 3 * P || n_done != 1) begin
      errors++;
      $display("FAIL burst3_counts: got en=%0d done=%0d want %0d/1", n_en, n_done, 3 * P);
    end
    n_en = 0; n_done = 0;
    burst_len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      burst_go = (i == 0);
      tick();
      burst_go = 1'b0;
      n_en += (en != 0); n_done += done; n_busy += busy;
    end
    checks++;
    if (n_en != 0 || n_done != 1 || n_busy != 0) begin
      errors++;
      $display("FAIL burst0_counts: got en=%0d done=%0d busy=%0d want 0/1/0", n_en, n_done, n_busy);
    end
  endtask

  task automatic test_halt();
    int n_en = 0, n_done = 0;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      halt = (i == 6);
      tick();
      halt = 1'b0;
      if (i >= 6 && n_done == 0) n_en += (en != 0);
      n_done += done;
      if (done) run = 1'b0;
      checks++;
      if ({en, phase, busy, done} !== exp_vec()) begin
        errors++;
        $display("FAIL halt[%0d]: got %b want %b", i, {en, phase, busy, done}, exp_vec());
      end
    end
    run = 1'b0;
    checks++;
    if (n_en != 2 || n_done != 1) begin
      errors++;
      $display("FAIL halt_counts: got en_after_halt=%0d done=%0d want 2/1", n_en, n_done);
    end
  endtask

  task automatic test_ignored();
    int n_en = 0, n_done = 0;
    for (int i = 0; i < 16; i++) begin
      burst_len = (i == 0) ? 8'd2 : 8'd7;
      burst_go  = (i == 0) || (i == 5);
      step      = (i == 3);
      run       = (i == 6);
      halt      = (i == 12);
      tick();
      burst_go = 1'b0; step = 1'b0; run = 1'b0; halt = 1'b0;
      n_en += (en != 0); n_done += done;
      checks++;
      if ({en, phase, busy, done} !== exp_vec()) begin
        errors++;
        $display("FAIL ignored[%0d]: got %b want %b", i, {en, phase, busy, done}, exp_vec());
      end
    end
    checks++;
    if (n_en != 2 * P || n_done != 1) begin
      errors++;
      $display("FAIL ignored_counts: got en=%0d done=%0d want %0d/1", n_en, n_done, 2 * P);
    end
  endtask

  task automatic test_reset_mid();
    int n_en = 0;
    burst_len = 8'd5;
    for (int i = 0; i < 13; i++) begin
      burst_go = (i == 0);
      rst      = (i == 3);
      step     = (i == 4);
      tick();
      burst_go = 1'b0; rst = 1'b0; step = 1'b0;
      if (i == 2) begin
        checks++;
        if (phase !== 2'd2) begin
          errors++;
          $display("FAIL rst_mid_setup: got phase=%0d want 2", phase);
        end
      end
      if (i == 3) begin
        checks++;
        if (en !== 4'b0000 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_clear: got en=%b busy=%b want 0000/0", en, busy);
        end
      end
      if (i >= 4) n_en += (en != 0);
      checks++;
      if ({en, phase, busy, done} !== exp_vec()) begin
        errors++;
        $display("FAIL rst_mid[%0d]: got %b want %b", i, {en, phase, busy, done}, exp_vec());
      end
    end
    checks++;
    if (n_en != P) begin
      errors++;
      $display("FAIL rst_mid_step: got %0d enables want %0d", n_en, P);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step      = ($urandom_range(0, 7) == 0);
      burst_go  = ($urandom_range(0, 7) == 0);
      burst_len = 8'($urandom_range(0, 3));
      halt      = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 79) == 0);
      tick();
      checks++;
      if ({en, phase, busy, done} !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %b want %b", i, {en, phase, busy, done}, exp_vec());
      end
      if ((en & (en - 4'd1)) != 0) begin
        errors++;
        $display("FAIL onehot[%0d]: got en=%b want at most one bit", i, en);
      end
    end
    run = 1'b0; step = 1'b0; burst_go = 1'b0; halt = 1'b0; rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if ({en, phase, busy, done} !== exp_vec()) begin
      errors++;
      $display("FAIL random_settle: got %b want %b", {en, phase, busy, done}, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_burst();
    test_halt();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
